// File: rtl/layer_sequencer_pkg.sv
// Shared types and sizing for the fully-connected layer sequencer.
package layer_sequencer_pkg;
    localparam int NU_COUNT     = 4;
    localparam int XY_MEM_DEPTH = 8;
    localparam int W_MEM_DEPTH  = 8;
    localparam int ACT_LATENCY  = 1;
    // Term/cycle counters must hold in_len+1 when the bias term is enabled.
    localparam int CNT_W        = XY_MEM_DEPTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        FLUSH,
        LOAD,
        SHIFT,
        FIN
    } seq_state_t;
endpackage

// File: rtl/layer_sequencer_write_delay_line.sv
// Fixed-depth shift of {valid, addr} aligning xy write-back with the activation result.
module write_delay_line #(
    parameter int STAGES = 2,
    parameter int AW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          out_vld,
    output logic [AW-1:0] out_addr
);
    logic [STAGES-1:0]         vld_pipe;
    logic [STAGES-1:0][AW-1:0] addr_pipe;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else begin
            vld_pipe[0]  <= in_vld;
            addr_pipe[0] <= in_addr;
            for (int i = 1; i < STAGES; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                addr_pipe[i] <= addr_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[STAGES-1];
    assign out_addr = addr_pipe[STAGES-1];
endmodule

// File: rtl/layer_sequencer.sv
// Sequences one FC layer through the MAC array, NU_COUNT neurons per group.
// Define LAYER_SEQ_BIAS_EN to add cfg_bias_addr and one bias MAC term per group.
module layer_sequencer
    import layer_sequencer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [XY_MEM_DEPTH-1:0] cfg_in_base,
    input  logic [XY_MEM_DEPTH-1:0] cfg_in_len,
    input  logic [XY_MEM_DEPTH-1:0] cfg_out_base,
    input  logic [XY_MEM_DEPTH-1:0] cfg_out_len,
    input  logic [W_MEM_DEPTH-1:0]  cfg_w_base,
`ifdef LAYER_SEQ_BIAS_EN
    input  logic [XY_MEM_DEPTH-1:0] cfg_bias_addr,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [XY_MEM_DEPTH-1:0] xy_read_addr,
    output logic [W_MEM_DEPTH-1:0]  w_addr,
    output logic                    mac_acc_update,
    output logic                    mac_acc_loopback,
    output logic                    serializer_update,
    output logic                    serializer_shift,
    output logic                    xy_write_enable,
    output logic [XY_MEM_DEPTH-1:0] xy_write_addr
);
`ifdef LAYER_SEQ_BIAS_EN
    localparam logic [CNT_W-1:0] BIAS_TERMS = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] BIAS_TERMS = '0;
`endif
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] NU_C      = CNT_W'(NU_COUNT);
    localparam logic [CNT_W-1:0] ACT_LAT_C = CNT_W'(ACT_LATENCY);

    seq_state_t              state, nxt_state;
    logic [CNT_W-1:0]        k, nxt_k, cnt, nxt_cnt;
    logic [CNT_W-1:0]        n_terms, rem_w, grp_n;
    logic [XY_MEM_DEPTH-1:0] in_base_q, in_len_q, rem, out_ptr;
    logic [XY_MEM_DEPTH-1:0] nxt_in_base, nxt_in_len, nxt_rem, nxt_xy;
    logic [W_MEM_DEPTH-1:0]  w_grp, nxt_w_grp, nxt_w;
    logic                    issue, addr_vld, addr_first, wr_vld;
`ifdef LAYER_SEQ_BIAS_EN
    logic [XY_MEM_DEPTH-1:0] bias_q, nxt_bias;
`endif

    assign n_terms = CNT_W'(in_len_q) + BIAS_TERMS;
    assign rem_w   = CNT_W'(rem);
    assign grp_n   = (rem_w > NU_C) ? NU_C : rem_w;

    always_comb begin
        nxt_state   = state;
        nxt_k       = k;
        nxt_cnt     = cnt;
        nxt_in_base = in_base_q;
        nxt_in_len  = in_len_q;
        nxt_rem     = rem;
        nxt_w_grp   = w_grp;
        issue       = 1'b0;
        case (state)
            IDLE: if (start) begin
                nxt_in_base = cfg_in_base;
                nxt_in_len  = cfg_in_len;
                nxt_rem     = cfg_out_len;
                nxt_w_grp   = cfg_w_base;
                if (cfg_in_len == '0 || cfg_out_len == '0) begin
                    nxt_state = FIN;
                end else begin
                    nxt_state = MAC;
                    nxt_k     = '0;
                    issue     = 1'b1;
                end
            end
            MAC: begin
                if (k == n_terms - ONE) begin
                    nxt_state = FLUSH;
                end else begin
                    nxt_k = k + ONE;
                    issue = 1'b1;
                end
            end
            FLUSH: nxt_state = LOAD;
            LOAD: begin
                nxt_state = SHIFT;
                nxt_cnt   = '0;
            end
            // SHIFT lasts until the group's last write is on the bus.
            SHIFT: begin
                if (cnt == grp_n + ACT_LAT_C - ONE) begin
                    if (rem_w > NU_C) begin
                        nxt_state = MAC;
                        nxt_k     = '0;
                        nxt_rem   = rem - XY_MEM_DEPTH'(NU_COUNT);
                        nxt_w_grp = w_grp + W_MEM_DEPTH'(n_terms);
                        issue     = 1'b1;
                    end else begin
                        nxt_state = FIN;
                    end
                end else begin
                    nxt_cnt = cnt + ONE;
                end
            end
            FIN:     nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        nxt_xy = nxt_in_base + nxt_k[XY_MEM_DEPTH-1:0];
`ifdef LAYER_SEQ_BIAS_EN
        nxt_bias = (state == IDLE && start) ? cfg_bias_addr : bias_q;
        if (nxt_k == CNT_W'(nxt_in_len)) nxt_xy = nxt_bias;
`endif
        nxt_w = nxt_w_grp + W_MEM_DEPTH'(nxt_k);
    end

    // Each serializer output slot (load cycle + shifts) produces one write.
    assign wr_vld = serializer_update | serializer_shift;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            k                 <= '0;
            cnt               <= '0;
            in_base_q         <= '0;
            in_len_q          <= '0;
            rem               <= '0;
            w_grp             <= '0;
            out_ptr           <= '0;
            addr_vld          <= 1'b0;
            addr_first        <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            xy_read_addr      <= '0;
            w_addr            <= '0;
            mac_acc_update    <= 1'b0;
            mac_acc_loopback  <= 1'b0;
            serializer_update <= 1'b0;
            serializer_shift  <= 1'b0;
        end else begin
            state             <= nxt_state;
            k                 <= nxt_k;
            cnt               <= nxt_cnt;
            in_base_q         <= nxt_in_base;
            in_len_q          <= nxt_in_len;
            rem               <= nxt_rem;
            w_grp             <= nxt_w_grp;
            if (state == IDLE && start) out_ptr <= cfg_out_base;
            else if (wr_vld)            out_ptr <= out_ptr + 1'b1;
            addr_vld          <= issue;
            addr_first        <= issue && (nxt_k == '0);
            busy              <= nxt_state inside {MAC, FLUSH, LOAD, SHIFT};
            done              <= nxt_state == FIN;
            xy_read_addr      <= issue ? nxt_xy : '0;
            w_addr            <= issue ? nxt_w : '0;
            mac_acc_update    <= addr_vld;
            mac_acc_loopback  <= addr_vld && !addr_first;
            serializer_update <= nxt_state == LOAD;
            serializer_shift  <= (nxt_state == SHIFT) && ((nxt_cnt + ONE) < grp_n);
        end
    end

`ifdef LAYER_SEQ_BIAS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) bias_q <= '0;
        else        bias_q <= nxt_bias;
    end
`endif

    write_delay_line #(
        .STAGES (ACT_LATENCY + 1),
        .AW     (XY_MEM_DEPTH)
    ) u_wr_dly (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (wr_vld),
        .in_addr  (out_ptr),
        .out_vld  (xy_write_enable),
        .out_addr (xy_write_addr)
    );
endmodule

// File: tb/tb_layer_sequencer.sv
// Randomized bench for layer_sequencer against a per-cycle timeline model of the layer.
module tb_layer_sequencer;
    import layer_sequencer_pkg::*;

    localparam int MAXC = 512;
    localparam int XM   = (1 << XY_MEM_DEPTH) - 1;
    localparam int WM   = (1 << W_MEM_DEPTH) - 1;
`ifdef LAYER_SEQ_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [XY_MEM_DEPTH-1:0] cfg_in_base = '0, cfg_in_len = '0, cfg_out_base = '0, cfg_out_len = '0;
    logic [W_MEM_DEPTH-1:0]  cfg_w_base = '0;
`ifdef LAYER_SEQ_BIAS_EN
    logic [XY_MEM_DEPTH-1:0] cfg_bias_addr = '0;
`endif
    logic busy, done, mac_acc_update, mac_acc_loopback;
    logic serializer_update, serializer_shift, xy_write_enable;
    logic [XY_MEM_DEPTH-1:0] xy_read_addr, xy_write_addr;
    logic [W_MEM_DEPTH-1:0]  w_addr;

    layer_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .cfg_in_base       (cfg_in_base),
        .cfg_in_len        (cfg_in_len),
        .cfg_out_base      (cfg_out_base),
        .cfg_out_len       (cfg_out_len),
        .cfg_w_base        (cfg_w_base),
`ifdef LAYER_SEQ_BIAS_EN
        .cfg_bias_addr     (cfg_bias_addr),
`endif
        .busy              (busy),
        .done              (done),
        .xy_read_addr      (xy_read_addr),
        .w_addr            (w_addr),
        .mac_acc_update    (mac_acc_update),
        .mac_acc_loopback  (mac_acc_loopback),
        .serializer_update (serializer_update),
        .serializer_shift  (serializer_shift),
        .xy_write_enable   (xy_write_enable),
        .xy_write_addr     (xy_write_addr)
    );

    always #5 clk = ~clk;

    // Expected value of every output, indexed by cycle since the start cycle.
    int e_busy[MAXC], e_done[MAXC], e_av[MAXC], e_xy[MAXC], e_w[MAXC], e_upd[MAXC];
    int e_lb[MAXC], e_su[MAXC], e_sh[MAXC], e_we[MAXC], e_wa[MAXC];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic build(input int ib, input int il, input int ob, input int ol,
                         input int wb, input int bi, output int total);
        int t, g, rem, n, len, s;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_av[i] = 0; e_xy[i] = 0; e_w[i] = 0; e_upd[i] = 0;
            e_lb[i] = 0; e_su[i] = 0; e_sh[i] = 0; e_we[i] = 0; e_wa[i] = 0;
        end
        if (il == 0 || ol == 0) begin
            e_done[1] = 1;
            total = 2;
            return;
        end
        len = il + BIAS;
        t = 1; g = 0; rem = ol;
        while (rem > 0) begin
            n = (rem < NU_COUNT) ? rem : NU_COUNT;
            for (int kk = 0; kk < len; kk++) begin
                e_av[t+kk]    = 1;
                e_xy[t+kk]    = (kk == il) ? bi : ((ib + kk) & XM);
                e_w[t+kk]     = (wb + g * len + kk) & WM;
                e_upd[t+kk+1] = 1;
                e_lb[t+kk+1]  = (kk != 0) ? 1 : 0;
            end
            s = t + len + 1;
            e_su[s] = 1;
            for (int c = s + 1; c < s + n; c++) e_sh[c] = 1;
            for (int j = 0; j < n; j++) begin
                e_we[s+1+ACT_LATENCY+j] = 1;
                e_wa[s+1+ACT_LATENCY+j] = (ob + g * NU_COUNT + j) & XM;
            end
            for (int c = t; c <= s + ACT_LATENCY + n; c++) e_busy[c] = 1;
            t = s + ACT_LATENCY + n + 1;
            g++;
            rem -= n;
        end
        e_done[t] = 1;
        total = t + 1;
    endtask

    task automatic check_cycle(input int c);
        cyc = c;
        check("busy", busy, e_busy[c]);
        check("done", done, e_done[c]);
        check("mac_acc_update", mac_acc_update, e_upd[c]);
        check("mac_acc_loopback", mac_acc_loopback, e_lb[c]);
        check("serializer_update", serializer_update, e_su[c]);
        check("serializer_shift", serializer_shift, e_sh[c]);
        check("xy_write_enable", xy_write_enable, e_we[c]);
        if (e_av[c] != 0) begin
            check("xy_read_addr", xy_read_addr, e_xy[c]);
            check("w_addr", w_addr, e_w[c]);
        end
        if (e_we[c] != 0) check("xy_write_addr", xy_write_addr, e_wa[c]);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_xy_read_addr"}, xy_read_addr, 0);
        check({tag, "_w_addr"}, w_addr, 0);
        check({tag, "_upd"}, mac_acc_update, 0);
        check({tag, "_lb"}, mac_acc_loopback, 0);
        check({tag, "_su"}, serializer_update, 0);
        check({tag, "_sh"}, serializer_shift, 0);
        check({tag, "_we"}, xy_write_enable, 0);
        check({tag, "_xy_write_addr"}, xy_write_addr, 0);
    endtask

    task automatic apply_start(input int ib, input int il, input int ob, input int ol,
                               input int wb, input int bi);
        @(posedge clk); #1;
        start        = 1'b1;
        cfg_in_base  = XY_MEM_DEPTH'(ib);
        cfg_in_len   = XY_MEM_DEPTH'(il);
        cfg_out_base = XY_MEM_DEPTH'(ob);
        cfg_out_len  = XY_MEM_DEPTH'(ol);
        cfg_w_base   = W_MEM_DEPTH'(wb);
`ifdef LAYER_SEQ_BIAS_EN
        cfg_bias_addr = XY_MEM_DEPTH'(bi);
`endif
        @(negedge clk);
        check_cycle(0);
    endtask

    // Runs one layer; with perturb, cfg and start are scrambled while the layer is active.
    task automatic run_layer(input int ib, input int il, input int ob, input int ol,
                             input int wb, input int bi, input bit perturb);
        int total;
        build(ib, il, ob, ol, wb, bi, total);
        apply_start(ib, il, ob, ol, wb, bi);
        for (int c = 1; c <= total; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (perturb && c < total) begin
                start        = 1'($urandom_range(0, 1));
                cfg_in_base  = XY_MEM_DEPTH'($urandom);
                cfg_in_len   = XY_MEM_DEPTH'($urandom);
                cfg_out_base = XY_MEM_DEPTH'($urandom);
                cfg_out_len  = XY_MEM_DEPTH'($urandom);
                cfg_w_base   = W_MEM_DEPTH'($urandom);
`ifdef LAYER_SEQ_BIAS_EN
                cfg_bias_addr = XY_MEM_DEPTH'($urandom);
`endif
            end
            @(negedge clk);
            check_cycle(c);
        end
    endtask

    initial begin
        int total;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 reset = 1'b1;

        run_layer(10, 3, 100, 4, 20, 0, 1'b0);     // single full group
        run_layer(10, 3, 100, 6, 20, 0, 1'b0);     // full + partial group
        run_layer(10, 0, 100, 4, 20, 0, 1'b0);     // empty input
        run_layer(10, 3, 100, 0, 20, 0, 1'b0);     // empty output
        run_layer(254, 4, 253, 5, 250, 77, 1'b0);  // address wrap
        run_layer(30, 5, 40, 9, 60, 9, 1'b1);      // busy-time start/cfg ignored

        // Reset in the middle of SHIFT drops pending writes.
        build(10, 3, 100, 4, 20, 0, total);
        apply_start(10, 3, 100, 4, 20, 0);
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            check_cycle(c);
        end
        @(posedge clk); #1 reset = 1'b0;
        #1 check_zero("rst_mid");
        repeat (3) begin
            @(negedge clk);
            check_zero("rst_hold");
        end
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_zero("post_rst");
        end
        run_layer(10, 3, 100, 4, 20, 0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            run_layer(int'($urandom_range(0, 255)), int'($urandom_range(0, 10)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 13)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
